// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: slot phases,
// polarity helpers and the slot timing derivations.
package seg_pkg;

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_DRIVE = 2'd1,
        PH_DARK  = 2'd2
    } phase_e;

    // Clocks per digit slot (integer division, fractional remainder dropped).
    function automatic int calc_slot(input int clk_fre, input int scan_fre, input int digits);
        return clk_fre / (scan_fre * digits);
    endfunction

    function automatic int calc_active(input int slot, input int blank_cycles);
        return slot - blank_cycles;
    endfunction

    function automatic int calc_step(input int active);
        return active / 15;
    endfunction

    // Counter width able to hold 0..slot.
    function automatic int calc_cnt_width(input int slot);
        return $clog2(slot + 1);
    endfunction

    function automatic logic sel_on_level(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [7:0] seg_off_pattern(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter, digit index and BLANK/DRIVE/DARK phase sequencer for one
// digit slot; the DRIVE length scales with the brightness it is given.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int DIGITS       = 6,
    parameter int SLOT         = 20,
    parameter int ACTIVE       = 18,
    parameter int STEP         = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int CW           = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bright_i,
    output phase_e     phase_o,
    output logic [2:0] digit_o,
    output logic       frame_tick_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    phase_e        state_q, state_d;

    logic [CW-1:0] on_len;
    logic [CW-1:0] drive_last;
    logic          slot_last;

    always_comb begin
        on_len = '0;
        if (bright_i == 4'd15) begin
            on_len = CW'(ACTIVE);
        end else begin
            on_len = CW'(bright_i) * CW'(STEP);
        end
    end

    assign drive_last = CW'(BLANK_CYCLES - 1) + on_len;
    assign slot_last  = (cnt_q == CW'(SLOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            dig_q   <= '0;
            state_q <= PH_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        cnt_d   = slot_last ? '0 : cnt_q + CW'(1);
        dig_d   = dig_q;
        state_d = state_q;
        if (slot_last) begin
            dig_d   = (dig_q == 3'(DIGITS - 1)) ? 3'd0 : dig_q + 3'd1;
            state_d = PH_BLANK;
        end else begin
            case (state_q)
                // A zero-length drive window goes straight to the dark tail.
                PH_BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = (on_len == '0) ? PH_DARK : PH_DRIVE;
                end
                PH_DRIVE: if (cnt_q == drive_last) begin
                    state_d = PH_DARK;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign phase_o      = state_q;
    assign digit_o      = dig_q;
    assign frame_tick_o = (cnt_q == '0) && (dig_q == 3'd0);

endmodule

// File: rtl/seg_scan_dim.sv
// Multiplexed seven-segment scanner with anti-ghost blanking and PWM-style
// brightness; inputs are sampled once per frame, all outputs are registered.
module seg_scan_dim
    import seg_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int CLK_FRE        = 50000000,
    parameter int SCAN_FRE       = 200,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*8-1:0]   seg_data_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [7:0]            seg_data,
    output logic                  frame_start,
    output logic [2:0]            cur_digit
);

    localparam int SLOT   = calc_slot(CLK_FRE, SCAN_FRE, DIGITS);
    localparam int ACTIVE = calc_active(SLOT, BLANK_CYCLES);
    localparam int STEP   = calc_step(ACTIVE);
    localparam int CW     = calc_cnt_width(SLOT);

    localparam logic              SEL_ON  = sel_on_level(SEL_ACTIVE_LOW);
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{~SEL_ON}};
    localparam logic [7:0]        SEG_OFF = seg_off_pattern(SEG_ACTIVE_LOW);

    generate
        if (ACTIVE < 15 || BLANK_CYCLES < 1 || DIGITS < 1 || DIGITS > 8) begin : g_bad_params
            $error("seg_scan_dim: illegal parameters (need ACTIVE>=15, BLANK_CYCLES>=1, DIGITS 1..8)");
        end
    endgenerate

    phase_e     phase;
    logic [2:0] digit;
    logic       frame_tick;
    logic [3:0] bright_cur;

    // Frame snapshot of the display inputs.
    logic [DIGITS*8-1:0] snap_seg_q;
    logic [DIGITS-1:0]   snap_en_q;
    logic [3:0]          snap_bright_q;

    // The timer sees the incoming brightness in the snapshot cycle itself.
    assign bright_cur = frame_tick ? bright : snap_bright_q;

    seg_slot_timer #(
        .DIGITS       (DIGITS),
        .SLOT         (SLOT),
        .ACTIVE       (ACTIVE),
        .STEP         (STEP),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CW           (CW)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .bright_i     (bright_cur),
        .phase_o      (phase),
        .digit_o      (digit),
        .frame_tick_o (frame_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_seg_q    <= {DIGITS{SEG_OFF}};
            snap_en_q     <= '0;
            snap_bright_q <= '0;
        end else if (frame_tick) begin
            snap_seg_q    <= seg_data_in;
            snap_en_q     <= digit_en;
            snap_bright_q <= bright;
        end
    end

    logic [7:0]        en_pad;
    logic [63:0]       seg_pad;
    logic [7:0]        cur_pattern;
    logic              drive_en;
    logic [DIGITS-1:0] sel_hot;

    assign en_pad = 8'(snap_en_q);

    always_comb begin
        seg_pad                   = {8{SEG_OFF}};
        seg_pad[DIGITS*8-1:0]     = snap_seg_q;
    end

    assign cur_pattern = seg_pad[{digit, 3'b000} +: 8];
    assign drive_en    = (phase == PH_DRIVE) && en_pad[digit];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
        assign sel_hot[gi] = drive_en && (digit == 3'(gi));
    end

    logic [DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic [7:0]        seg_data_q, seg_data_d;
    logic              frame_start_q;
    logic [2:0]        cur_digit_q;

    always_comb begin
        seg_sel_d  = SEL_ON ? sel_hot : ~sel_hot;
        seg_data_d = drive_en ? cur_pattern : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel_q     <= SEL_OFF;
            seg_data_q    <= SEG_OFF;
            frame_start_q <= 1'b0;
            cur_digit_q   <= 3'd0;
        end else begin
            seg_sel_q     <= seg_sel_d;
            seg_data_q    <= seg_data_d;
            frame_start_q <= frame_tick;
            cur_digit_q   <= digit;
        end
    end

    assign seg_sel     = seg_sel_q;
    assign seg_data    = seg_data_q;
    assign frame_start = frame_start_q;
    assign cur_digit   = cur_digit_q;

endmodule

// File: tb/tb_seg_scan_dim.sv
// Directed bench for seg_scan_dim at SLOT=20, ACTIVE=18, STEP=1, six digits.
module tb_seg_scan_dim;

    localparam logic [47:0] PAT_A = 48'h050403020100;
    localparam logic [47:0] PAT_B = 48'hC0F9A4B09992;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] seg_data_in = PAT_A;
    logic [5:0]  digit_en = 6'h3F;
    logic [3:0]  bright = 4'd15;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_data;
    logic        frame_start;
    logic [2:0]  cur_digit;

    int tests = 0;
    int fails = 0;
    int inv_errs = 0;

    always #5 clk = ~clk;

    seg_scan_dim #(
        .DIGITS         (6),
        .CLK_FRE        (1200),
        .SCAN_FRE       (10),
        .BLANK_CYCLES   (2),
        .SEL_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_data_in (seg_data_in),
        .digit_en    (digit_en),
        .bright      (bright),
        .seg_sel     (seg_sel),
        .seg_data    (seg_data),
        .frame_start (frame_start),
        .cur_digit   (cur_digit)
    );

    // Per-cycle invariants: at most one select low; segments dark when none is.
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(~seg_sel) > 1) inv_errs <= inv_errs + 1;
            else if (seg_sel == 6'h3F && seg_data != 8'hFF) inv_errs <= inv_errs + 1;
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  br;
        logic [5:0]  en;
        logic [47:0] pat;
        int          t;
        logic [5:0]  sel;
        logic [7:0]  data;
        logic        fs;
        logic [2:0]  dig;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [3:0] br, input logic [5:0] en,
                           input logic [47:0] pat, input int t, input logic [5:0] sel,
                           input logic [7:0] data, input logic fs, input logic [2:0] dig);
        vec_t v;
        v.name = name; v.br = br; v.en = en; v.pat = pat; v.t = t;
        v.sel = sel; v.data = data; v.fs = fs; v.dig = dig;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [5:0] es, input logic [7:0] ed,
                         input logic ef, input logic [2:0] eg);
        tests++;
        if (seg_sel !== es || seg_data !== ed || frame_start !== ef || cur_digit !== eg) begin
            fails++;
            $display("FAIL %s: got sel=%b data=%h fs=%b dig=%0d, required sel=%b data=%h fs=%b dig=%0d",
                     name, seg_sel, seg_data, frame_start, cur_digit, es, ed, ef, eg);
        end else begin
            $display("[TB] ok %s: sel=%b data=%h fs=%b dig=%0d", name, seg_sel, seg_data, frame_start, cur_digit);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end else begin
            $display("[TB] ok %s: %0d", name, got);
        end
    endtask

    // Reset, then release on a falling edge so the next rising edge is the first clock.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance so that outputs describe frame cycle t (first clock after release is t=0).
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run 240 cycles from reset, collecting select activity and frame pulse placement.
    task automatic run_frames(input logic [3:0] br, input logic [5:0] en,
                              output int active, output int pulses, output int badpos,
                              output int dig3_start);
        bright = br; digit_en = en; seg_data_in = PAT_A;
        active = 0; pulses = 0; badpos = 0; dig3_start = -1;
        do_reset();
        for (int n = 0; n < 240; n++) begin
            step(1);
            if (seg_sel != 6'h3F) active++;
            if (frame_start) begin
                pulses++;
                if (n % 120 != 0) badpos++;
            end
            if (cur_digit == 3'd3 && dig3_start < 0) dig3_start = n;
        end
    endtask

    int act, pul, bad, d3;

    initial begin
        // Reset state
        #12;
        check("reset_state", 6'h3F, 8'hFF, 1'b0, 3'd0);

        add_vec("b15_t0_frame",     4'd15, 6'h3F, PAT_A,   0, 6'h3F, 8'hFF, 1'b1, 3'd0);
        add_vec("b15_t1_blank",     4'd15, 6'h3F, PAT_A,   1, 6'h3F, 8'hFF, 1'b0, 3'd0);
        add_vec("b15_t2_drive0",    4'd15, 6'h3F, PAT_A,   2, 6'h3E, 8'h00, 1'b0, 3'd0);
        add_vec("b15_t19_last",     4'd15, 6'h3F, PAT_A,  19, 6'h3E, 8'h00, 1'b0, 3'd0);
        add_vec("b15_t20_blank1",   4'd15, 6'h3F, PAT_A,  20, 6'h3F, 8'hFF, 1'b0, 3'd1);
        add_vec("b15_t22_drive1",   4'd15, 6'h3F, PAT_A,  22, 6'h3D, 8'h01, 1'b0, 3'd1);
        add_vec("b15_t65_drive3",   4'd15, 6'h3F, PAT_A,  65, 6'h37, 8'h03, 1'b0, 3'd3);
        add_vec("b15_t119_drive5",  4'd15, 6'h3F, PAT_A, 119, 6'h1F, 8'h05, 1'b0, 3'd5);
        add_vec("b15_t120_frame",   4'd15, 6'h3F, PAT_A, 120, 6'h3F, 8'hFF, 1'b1, 3'd0);
        add_vec("b5_t6_lastdrive",  4'd5,  6'h3F, PAT_A,   6, 6'h3E, 8'h00, 1'b0, 3'd0);
        add_vec("b5_t7_dark",       4'd5,  6'h3F, PAT_A,   7, 6'h3F, 8'hFF, 1'b0, 3'd0);
        add_vec("b5_t46_drive2",    4'd5,  6'h3F, PAT_A,  46, 6'h3B, 8'h02, 1'b0, 3'd2);
        add_vec("b5_t47_dark2",     4'd5,  6'h3F, PAT_A,  47, 6'h3F, 8'hFF, 1'b0, 3'd2);
        add_vec("b0_t2_off",        4'd0,  6'h3F, PAT_A,   2, 6'h3F, 8'hFF, 1'b0, 3'd0);
        add_vec("b0_t62_off",       4'd0,  6'h3F, PAT_A,  62, 6'h3F, 8'hFF, 1'b0, 3'd3);
        add_vec("en3B_t45_dig2off", 4'd15, 6'h3B, PAT_A,  45, 6'h3F, 8'hFF, 1'b0, 3'd2);
        add_vec("en3B_t60_blank3",  4'd15, 6'h3B, PAT_A,  60, 6'h3F, 8'hFF, 1'b0, 3'd3);
        add_vec("en3B_t62_drive3",  4'd15, 6'h3B, PAT_A,  62, 6'h37, 8'h03, 1'b0, 3'd3);
        add_vec("b1_t82_drive4",    4'd1,  6'h3F, PAT_A,  82, 6'h2F, 8'h04, 1'b0, 3'd4);
        add_vec("b1_t83_dark4",     4'd1,  6'h3F, PAT_A,  83, 6'h3F, 8'hFF, 1'b0, 3'd4);
        add_vec("b14_t15_drive0",   4'd14, 6'h3F, PAT_A,  15, 6'h3E, 8'h00, 1'b0, 3'd0);
        add_vec("b14_t16_dark0",    4'd14, 6'h3F, PAT_A,  16, 6'h3F, 8'hFF, 1'b0, 3'd0);
        add_vec("patB_t30_drive1",  4'd15, 6'h3F, PAT_B,  30, 6'h3D, 8'h99, 1'b0, 3'd1);
        add_vec("patB_t105_drive5", 4'd15, 6'h3F, PAT_B, 105, 6'h1F, 8'hC0, 1'b0, 3'd5);

        foreach (vecs[i]) begin
            bright = vecs[i].br; digit_en = vecs[i].en; seg_data_in = vecs[i].pat;
            do_reset();
            step(vecs[i].t + 1);
            check(vecs[i].name, vecs[i].sel, vecs[i].data, vecs[i].fs, vecs[i].dig);
        end

        // Whole-frame activity and frame_start spacing
        run_frames(4'd15, 6'h3F, act, pul, bad, d3);
        check_int("b15_active_cycles", act, 216);
        check_int("b15_frame_pulses", pul, 2);
        check_int("b15_frame_badpos", bad, 0);
        run_frames(4'd5, 6'h3F, act, pul, bad, d3);
        check_int("b5_active_cycles", act, 60);
        run_frames(4'd0, 6'h3F, act, pul, bad, d3);
        check_int("b0_active_cycles", act, 0);
        run_frames(4'd15, 6'h3B, act, pul, bad, d3);
        check_int("en3B_active_cycles", act, 180);
        check_int("en3B_dig3_start", d3, 60);

        // Mid-frame data change is held off until the next frame
        bright = 4'd15; digit_en = 6'h3F; seg_data_in = PAT_A;
        do_reset();
        step(63);
        check("chg_t62_before", 6'h37, 8'h03, 1'b0, 3'd3);
        seg_data_in = PAT_B;
        step(3);
        check("chg_t65_held", 6'h37, 8'h03, 1'b0, 3'd3);
        step(40);
        check("chg_t105_held", 6'h1F, 8'h05, 1'b0, 3'd5);
        step(15);
        check("chg_t120_frame", 6'h3F, 8'hFF, 1'b1, 3'd0);
        step(2);
        check("chg_t122_new", 6'h3E, 8'h92, 1'b0, 3'd0);
        step(60);
        check("chg_t182_new3", 6'h37, 8'hA4, 1'b0, 3'd3);

        // Asynchronous reset in the middle of digit 2's drive window
        seg_data_in = PAT_A;
        do_reset();
        step(48);
        check("rst_t47_before", 6'h3B, 8'h02, 1'b0, 3'd2);
        rst_n = 1'b0;
        #2;
        check("rst_async_values", 6'h3F, 8'hFF, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("rst_first_clock", 6'h3F, 8'hFF, 1'b1, 3'd0);
        step(2);
        check("rst_restart_drive0", 6'h3E, 8'h00, 1'b0, 3'd0);

        @(negedge clk);
        check_int("invariant_violations", inv_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_dim.md
SEG_SCAN_DIM -- requirements
Module: seg_scan_dim

Interface
REQ-001 Parameter DIGITS, default 6: number of multiplexed digits, legal 1..8.
REQ-002 Parameter CLK_FRE, default 50000000: clock frequency in Hz.
REQ-003 Parameter SCAN_FRE, default 200: full-frame refresh rate in Hz.
REQ-004 Parameter BLANK_CYCLES, default 500: anti-ghosting dead time at the start of each digit slot, in clocks.
REQ-005 Parameter SEL_ACTIVE_LOW, default 1: digit select polarity (1 = low turns a digit on).
REQ-006 Parameter SEG_ACTIVE_LOW, default 1: segment polarity (1 = low lights a segment).
REQ-007 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-008 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 Port seg_data_in, input, DIGITS*8: packed segment patterns, digit k at bits [8k+7:8k], already in SEG polarity.
REQ-010 Port digit_en, input, DIGITS: per-digit enable mask.
REQ-011 Port bright, input, 4: global brightness 0..15.
REQ-012 Port seg_sel, output, DIGITS: registered digit select, one-hot active in SEL polarity.
REQ-013 Port seg_data, output, 8: registered segment drive.
REQ-014 Port frame_start, output, 1: single-cycle pulse at the start of each frame.
REQ-015 Port cur_digit, output, 3: index of the digit whose slot is current.

Function
REQ-016 SLOT = CLK_FRE/(SCAN_FRE*DIGITS) (integer), ACTIVE = SLOT-BLANK_CYCLES, STEP = ACTIVE/15; elaboration SHALL fail if ACTIVE < 15.
REQ-017 A slot counter SHALL run 0..SLOT-1, then wrap to 0 and advance cur_digit; cur_digit SHALL wrap from DIGITS-1 to 0.
REQ-018 Per slot, FSM states BLANK -> DRIVE -> DARK -> BLANK (next digit), with the phase given by the slot counter.
REQ-019 BLANK: counter 0..BLANK_CYCLES-1; all selects inactive and all segments inactive.
REQ-020 DRIVE: the next ON cycles, where ON = ACTIVE if bright==15, else bright*STEP; select for cur_digit active; seg_data = that digit's snapshot pattern.
REQ-021 DARK: remainder of the slot; outputs as in BLANK; bright==0 skips DRIVE entirely.
REQ-022 A digit with its snapshot digit_en bit at 0 SHALL keep its slot length but drive as BLANK for the whole slot.
REQ-023 seg_data_in, digit_en and bright SHALL be snapshotted only when the counter is 0 and cur_digit is 0; mid-frame input changes SHALL take effect at the next frame.
REQ-024 frame_start SHALL be high for exactly the one cycle in which that snapshot is taken.
REQ-025 Outputs SHALL be registered, lagging the counter/state decode by exactly one clock; seg_sel SHALL never have two active bits.

Reset
REQ-026 While rst_n is low: seg_sel all inactive, seg_data all inactive (8'hFF when SEG_ACTIVE_LOW), frame_start 0, cur_digit 0, counter 0, state BLANK, snapshot cleared to all-inactive with digit_en 0.
REQ-027 Reset asserted mid-slot SHALL force the reset values asynchronously; after release, the first frame SHALL start with digit 0 and take a snapshot on the first clock.

Structure
REQ-028 Polarity helper constants and the SLOT/ACTIVE/STEP derivations SHALL live in shared package seg_pkg.
REQ-029 The slot counter, FSM and ON computation SHALL form sub-module seg_slot_timer, which outputs the phase and digit index; the top holds the snapshot and output registers.

Verification (CLK_FRE=1200, SCAN_FRE=10, DIGITS=6, BLANK_CYCLES=2 -> SLOT=20, ACTIVE=18, STEP=1)
REQ-030 bright=15, all enabled, digit k pattern 8'h0k -> each digit selected for 18 cycles after 2 blank cycles; frame_start every 120 clocks.
REQ-031 bright=5 -> per slot: 2 blank, 5 drive, 13 dark; bright=0 -> seg_sel never active.
REQ-032 digit_en=6'b111011 -> digit 2's slot is fully inactive; digit 3 still starts at clock 60 of the frame.
REQ-033 Change seg_data_in while digit 3 is driving -> no output change until after the next frame_start.
REQ-034 rst_n pulsed low at clock 47 -> outputs inactive immediately; after release, frame_start on the first clock and digit 0 restarts.
REQ-035 Every cycle: assert one-hot-or-none on seg_sel, and assert segments inactive whenever no select is active.
